ex_muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_datapath.sv | 94 +++++++++
 rtl/ex_muldiv_unit.sv | 140 ++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the EX-stage multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned ITER_DEFAULT = 32;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// Accumulator/remainder datapath: shift-add multiply, restoring divide, sign fix-up.
// With MULDIV_FAST_MULT_EN the product comes from one combinational multiplier.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int unsigned ITER = ITER_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_is_div,
  input  logic              i_is_signed,
  input  logic [ITER-1:0]   i_a,
  input  logic [ITER-1:0]   i_b,
  output logic [2*ITER-1:0] o_result_c
);

  localparam int unsigned W = ITER;

  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_m;
  logic           r_is_div;
  logic           r_neg_q;
  logic           r_neg_r;
  logic           r_dz;
  logic           r_ovf;

  logic [W-1:0]   w_mag_a;
  logic [W-1:0]   w_mag_b;
  logic [W-1:0]   w_add;
  logic [W:0]     w_sum;
  logic [W:0]     w_trial;
  logic           w_ge;
  logic [W-1:0]   w_diff;
  logic [W-1:0]   w_rem_next;
  logic [2*W-1:0] w_prod;
  logic [2*W-1:0] w_mul_fix;
  logic [W-1:0]   w_q_fix;
  logic [W-1:0]   w_r_fix;

  assign w_mag_a = (i_is_signed && i_a[W-1]) ? (~i_a + W'(1)) : i_a;
  assign w_mag_b = (i_is_signed && i_b[W-1]) ? (~i_b + W'(1)) : i_b;

  // Multiply step: conditionally add multiplicand to the upper half, shift right
  assign w_add   = r_acc[0] ? r_m : '0;
  assign w_sum   = {1'b0, r_acc[2*W-1:W]} + {1'b0, w_add};

  // Divide step: shift in next dividend bit, subtract divisor if it fits
  assign w_trial    = {r_acc[2*W-1:W], r_acc[W-1]};
  assign w_ge       = (w_trial >= {1'b0, r_m});
  assign w_diff     = w_trial[W-1:0] - r_m;
  assign w_rem_next = w_ge ? w_diff : w_trial[W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_m      <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (i_load) begin
      r_acc    <= i_is_div ? {W'(0), w_mag_a} : {W'(0), w_mag_b};
      r_m      <= i_is_div ? w_mag_b : w_mag_a;
      r_is_div <= i_is_div;
      r_neg_q  <= i_is_signed && (i_a[W-1] ^ i_b[W-1]);
      r_neg_r  <= i_is_signed && i_a[W-1];
      r_dz     <= i_is_div && !i_is_signed && (i_b == '0);
      r_ovf    <= i_is_div && i_is_signed && (i_a == W'(INT_MIN)) && (i_b == '1);
    end else if (i_step) begin
      r_acc    <= r_is_div ? {w_rem_next, r_acc[W-2:0], w_ge}
                           : {w_sum, r_acc[W-1:1]};
    end
  end

`ifdef MULDIV_FAST_MULT_EN
  assign w_prod = (2*W)'(r_m) * (2*W)'(r_acc[W-1:0]);
`else
  assign w_prod = r_acc;
`endif

  // Sign correction; remainder follows the dividend's sign
  assign w_mul_fix = r_neg_q ? -w_prod : w_prod;
  assign w_q_fix   = r_dz    ? W'(DIV0_LO) :
                     r_ovf   ? W'(INT_MIN) :
                     r_neg_q ? -r_acc[W-1:0] : r_acc[W-1:0];
  assign w_r_fix   = r_ovf   ? '0 :
                     r_neg_r ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];

  assign o_result_c = r_is_div ? {w_r_fix, w_q_fix} : w_mul_fix;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit owning HI/LO: FSM, iteration counter, stall logic.
// Define MULDIV_FAST_MULT_EN for a single-cycle combinational multiply path.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned ITER = ITER_DEFAULT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Start,
  input  logic [2:0]      Op,
  input  logic [ITER-1:0] A,
  input  logic [ITER-1:0] B,
  input  logic            HiLoRead,
  input  logic            Hold,
  input  logic            Flush,
  output logic            Stall,
  output logic            Busy,
  output logic            Done,
  output logic [ITER-1:0] HI,
  output logic [ITER-1:0] LO
);

  localparam int unsigned CW = $clog2(ITER);

  state_t            r_state;
  state_t            w_state_next;
  logic [CW-1:0]     r_count;
  logic              r_busy;
  logic              r_done;
  logic [ITER-1:0]   r_hi;
  logic [ITER-1:0]   r_lo;

  muldiv_op_t        w_op;
  logic              w_accept;
  logic              w_is_md;
  logic              w_is_div;
  logic              w_is_signed;
  logic              w_load;
  logic              w_step;
  logic              w_wr_res;
  logic              w_wr_hi;
  logic              w_wr_lo;
  logic [2*ITER-1:0] w_result;

  assign w_op        = muldiv_op_t'(Op);
  assign w_is_md     = (w_op == MULT) || (w_op == MULTU) || (w_op == DIV) || (w_op == DIVU);
  assign w_is_div    = (w_op == DIV) || (w_op == DIVU);
  assign w_is_signed = (w_op == MULT) || (w_op == DIV);
  assign w_accept    = (r_state == IDLE) && Start && !Hold && !Flush;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && w_is_md) begin
`ifdef MULDIV_FAST_MULT_EN
          w_state_next = w_is_div ? RUN : FIXUP;
`else
          w_state_next = RUN;
`endif
        end
      end
      RUN:     if (r_count == CW'(ITER - 1)) w_state_next = FIXUP;
      FIXUP:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_load   = 1'b0;
    w_step   = 1'b0;
    w_wr_res = 1'b0;
    w_wr_hi  = 1'b0;
    w_wr_lo  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_load  = w_is_md;
          w_wr_hi = (w_op == MTHI);
          w_wr_lo = (w_op == MTLO);
        end
      end
      RUN:     w_step   = 1'b1;
      FIXUP:   w_wr_res = 1'b1;
      default: ;
    endcase
  end

  // Busy/Done registered from the next state so they line up with RUN/FIXUP
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_busy <= (w_state_next != IDLE);
      r_done <= (w_state_next == FIXUP);
      if (w_load)      r_count <= '0;
      else if (w_step) r_count <= r_count + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_wr_res) begin
      r_hi <= w_result[2*ITER-1:ITER];
      r_lo <= w_result[ITER-1:0];
    end else begin
      if (w_wr_hi) r_hi <= A;
      if (w_wr_lo) r_lo <= A;
    end
  end

  muldiv_datapath #(.ITER(ITER)) u_datapath (
    .clk         (CLK),
    .rst_n       (RST),
    .i_load      (w_load),
    .i_step      (w_step),
    .i_is_div    (w_is_div),
    .i_is_signed (w_is_signed),
    .i_a         (A),
    .i_b         (B),
    .o_result_c  (w_result)
  );

  assign Busy  = r_busy;
  assign Done  = r_done;
  assign HI    = r_hi;
  assign LO    = r_lo;
  assign Stall = r_busy && (Start || HiLoRead);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit with a queue of expected {HI,LO} results.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  logic        CLK;
  logic        RST;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        HiLoRead;
  logic        Hold;
  logic        Flush;
  logic        Stall;
  logic        Busy;
  logic        Done;
  logic [31:0] HI;
  logic [31:0] LO;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  ex_muldiv_unit dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Op(Op), .A(A), .B(B),
    .HiLoRead(HiLoRead), .Hold(Hold), .Flush(Flush),
    .Stall(Stall), .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    int ia, ib;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ia = a;
    ib = b;
    case (op)
      3'd0: begin p = sa * sb; return p; end
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(ia % ib), 32'(ia / ib)};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] pop_exp();
    if (exp_q.size() == 0) return 64'hx;
    return exp_q.pop_front();
  endfunction

  function automatic int lat_of(input logic [2:0] op);
    return (op <= 3'd1) ? MUL_LAT : DIV_LAT;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Op = op; A = a; B = b; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    if (op <= 3'd3) exp_q.push_back(model(op, a, b));
  endtask

  // Observe from the cycle after accept until Done; returns just after the HI/LO write edge
  task automatic wait_done(output int busy_n, output int done_at, output int stall_n);
    busy_n = 0; done_at = -1; stall_n = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge CLK);
      if (Busy)  busy_n++;
      if (Stall) stall_n++;
      if (Done) begin done_at = k; break; end
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RST = 1'b0; Start = 1'b0; Op = 3'd0; A = '0; B = '0;
    HiLoRead = 1'b1; Hold = 1'b0; Flush = 1'b0;
    #12;
    checks++; if (HI !== 32'd0)  begin errors++; $display("FAIL reset_hi: got %h want 0", HI); end
    checks++; if (LO !== 32'd0)  begin errors++; $display("FAIL reset_lo: got %h want 0", LO); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", Done); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", Stall); end
    @(negedge CLK);
    RST = 1'b1; HiLoRead = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_mult_timing();
    int bn, da, sn;
    logic [63:0] e;
    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    wait_done(bn, da, sn);
    e = pop_exp();
    checks++; if (bn !== MUL_LAT) begin errors++; $display("FAIL mult_busy_cycles: got %0d want %0d", bn, MUL_LAT); end
    checks++; if (da !== MUL_LAT) begin errors++; $display("FAIL mult_done_cycle: got %0d want %0d", da, MUL_LAT); end
    checks++; if ({HI, LO} !== 64'hFFFF_FFFF_FFFF_FFFA) begin errors++; $display("FAIL mult_neg2x3: got %h want FFFFFFFFFFFFFFFA", {HI, LO}); end
    checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL mult_model: got %h want %h", {HI, LO}, e); end
    checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL mult_idle_after: busy=%b done=%b want 0 0", Busy, Done); end
  endtask

  task automatic test_divu_stall();
    int bn, da, sn;
    logic [63:0] e;
    issue(3'd3, 32'd100, 32'd7);
    HiLoRead = 1'b1;
    wait_done(bn, da, sn);
    e = pop_exp();
    checks++; if (sn !== 33) begin errors++; $display("FAIL divu_stall_cycles: got %0d want 33", sn); end
    checks++; if (da !== 33) begin errors++; $display("FAIL divu_done_cycle: got %0d want 33", da); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL divu_read_no_stall: got %b want 0", Stall); end
    checks++; if ({HI, LO} !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_100_7: got %h want %h", {HI, LO}, {32'd2, 32'd14}); end
    checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL divu_model: got %h want %h", {HI, LO}, e); end
    HiLoRead = 1'b0;
  endtask

  task automatic test_div_cases();
    logic [2:0]  top_[6]  = '{3'd2, 3'd3, 3'd2, 3'd1, 3'd2, 3'd0};
    logic [31:0] ta_[6]   = '{32'hFFFF_FFF9, 32'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd7, 32'h8000_0000};
    logic [31:0] tb_[6]   = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h8000_0000};
    logic [63:0] fixed_[3] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'd5, 32'hFFFF_FFFF}, {32'd0, 32'h8000_0000}};
    int bn, da, sn;
    logic [63:0] e;
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 6; i++) begin
      issue(top_[i], ta_[i], tb_[i]);
      wait_done(bn, da, sn);
      e = pop_exp();
      checks++; if (da !== lat_of(top_[i])) begin errors++; $display("FAIL case%0d_done_cycle: got %0d want %0d", i, da, lat_of(top_[i])); end
      checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL case%0d_result: got %h want %h", i, {HI, LO}, e); end
      if (i < 3) begin
        checks++; if ({HI, LO} !== fixed_[i]) begin errors++; $display("FAIL case%0d_const: got %h want %h", i, {HI, LO}, fixed_[i]); end
      end
      if (i == 3) begin
        checks++; if ({HI, LO} !== {32'hFFFF_FFFE, 32'd1}) begin errors++; $display("FAIL multu_max: got %h want FFFFFFFE00000001", {HI, LO}); end
      end
    end
    for (int i = 0; i < 10; i++) begin
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 1) == 1) b = b & 32'h0000_00FF;
      if (op == 3'd2 && b == 32'd0) b = 32'd1;
      issue(op, a, b);
      wait_done(bn, da, sn);
      e = pop_exp();
      checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL rand%0d op=%0d a=%h b=%h: got %h want %h", i, op, a, b, {HI, LO}, e); end
    end
  endtask

  task automatic test_mtxx();
    issue(3'd4, 32'hA5A5_A5A5, 32'd0);
    issue(3'd5, 32'h0F0F_0F0F, 32'd0);
    checks++; if ({HI, LO} !== {32'hA5A5_A5A5, 32'h0F0F_0F0F}) begin errors++; $display("FAIL mt_setup: got %h want A5A5A5A50F0F0F0F", {HI, LO}); end
    Flush = 1'b1;
    issue(3'd4, 32'h1234_5678, 32'd0);
    Flush = 1'b0;
    checks++; if (HI !== 32'hA5A5_A5A5) begin errors++; $display("FAIL mthi_flush: got %h want A5A5A5A5", HI); end
    Hold = 1'b1;
    issue(3'd5, 32'h8765_4321, 32'd0);
    Hold = 1'b0;
    checks++; if (LO !== 32'h0F0F_0F0F) begin errors++; $display("FAIL mtlo_hold: got %h want 0F0F0F0F", LO); end
    issue(3'd4, 32'h1234_5678, 32'd0);
    checks++; if (HI !== 32'h1234_5678) begin errors++; $display("FAIL mthi: got %h want 12345678", HI); end
    checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL mthi_busy: busy=%b done=%b want 0 0", Busy, Done); end
    issue(3'd5, 32'h8765_4321, 32'd0);
    checks++; if ({HI, LO} !== {32'h1234_5678, 32'h8765_4321}) begin errors++; $display("FAIL mtlo: got %h want 1234567887654321", {HI, LO}); end
  endtask

  task automatic test_back_to_back();
    int bn, da, sn;
    logic [63:0] e, e2;
    issue(3'd1, 32'd123456, 32'd789);
    Op = 3'd3; A = 32'd1000; B = 32'd33; Start = 1'b1;
    e2 = model(3'd3, 32'd1000, 32'd33);
    exp_q.push_back(e2);
    wait_done(bn, da, sn);
    e = pop_exp();
    checks++; if (sn !== MUL_LAT) begin errors++; $display("FAIL b2b_stall_cycles: got %0d want %0d", sn, MUL_LAT); end
    checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL b2b_first: got %h want %h", {HI, LO}, e); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL b2b_release: got %b want 0", Stall); end
    @(posedge CLK); #1;
    Op = 3'd5; A = 32'hCAFE_F00D; Start = 1'b1;
    wait_done(bn, da, sn);
    e = pop_exp();
    checks++; if (sn !== 33) begin errors++; $display("FAIL b2b_div_stall: got %0d want 33", sn); end
    checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL b2b_second: got %h want %h", {HI, LO}, e); end
    @(posedge CLK); #1;
    Start = 1'b0;
    checks++; if ({HI, LO} !== {e2[63:32], 32'hCAFE_F00D}) begin errors++; $display("FAIL b2b_mtlo: got %h want %h", {HI, LO}, {e2[63:32], 32'hCAFE_F00D}); end
  endtask

  task automatic test_reset_mid_run();
    int dn;
    issue(3'd2, 32'd1000, 32'd3);
    repeat (10) @(posedge CLK);
    #2;
    RST = 1'b0; HiLoRead = 1'b1;
    #1;
    exp_q.delete();
    checks++; if ({HI, LO} !== 64'd0) begin errors++; $display("FAIL midrun_hilo: got %h want 0", {HI, LO}); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL midrun_busy: got %b want 0", Busy); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL midrun_stall: got %b want 0", Stall); end
    @(negedge CLK);
    RST = 1'b1; HiLoRead = 1'b0;
    dn = 0;
    repeat (40) begin
      @(negedge CLK);
      if (Done) dn++;
    end
    checks++; if (dn !== 0) begin errors++; $display("FAIL midrun_no_done: got %0d pulses want 0", dn); end
    @(posedge CLK); #1;
  endtask

  initial begin
    test_reset();
    test_mult_timing();
    test_divu_stall();
    test_div_cases();
    test_mtxx();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
